mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 41 ++++
 rtl/mem_access_unit_lane_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: RV32 MemOp (func3) values, FSM states,
// and helpers for MemOp legality and natural alignment.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } mau_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op inside {MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU};
  endfunction

  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      MOP_H, MOP_HU: return ~lo[0];
      MOP_W:         return lo == 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  // Low address bits forced to the natural boundary of the access size.
  function automatic logic [1:0] align_lo(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      MOP_H, MOP_HU: return {lo[1], 1'b0};
      MOP_W:         return 2'b00;
      default:       return lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store byte enables / replicated store data, and load
// byte/halfword extraction with sign or zero extension.
module mau_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    wmask      = 4'b1111;
    wdata_lane = wdata;
    case (mem_op)
      MOP_B, MOP_BU: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      MOP_H, MOP_HU: begin
        wmask      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    if (!is_store) wmask = '0;
  end

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = mem_rdata[7:0];
      2'd1:    rbyte = mem_rdata[15:8];
      2'd2:    rbyte = mem_rdata[23:16];
      default: rbyte = mem_rdata[31:24];
    endcase
    rhalf = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mem_op)
      MOP_B:   rdata_ext = {{24{rbyte[7]}}, rbyte};
      MOP_BU:  rdata_ext = {24'd0, rbyte};
      MOP_H:   rdata_ext = {{16{rhalf[15]}}, rhalf};
      MOP_HU:  rdata_ext = {16'd0, rhalf};
      default: rdata_ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit bridging the core to a word-wide bus.
// Define MAU_MISALIGN_CHECK_EN to reject misaligned h/hu/w with err instead of aligning.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemWr,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  mau_state_e  state;
  logic [2:0]  r_op;
  logic [1:0]  r_lo;
  logic [31:0] r_wdata;
  logic        acc_ok;
  logic [1:0]  acc_lo;
  logic [31:0] lane_rdata;

  always_comb begin
`ifdef MAU_MISALIGN_CHECK_EN
    acc_ok = op_legal(MemOp) && op_aligned(MemOp, addr[1:0]);
`else
    acc_ok = op_legal(MemOp);
`endif
    acc_lo = align_lo(MemOp, addr[1:0]);
  end

  // Lane logic runs off the captured request, so bus mask/data are flop-driven and
  // stay stable for the whole transaction; load extraction reuses the same fields.
  mau_lane_align u_lane (
    .is_store  (mem_we),
    .mem_op    (r_op),
    .addr_lo   (r_lo),
    .wdata     (r_wdata),
    .mem_rdata (mem_rdata),
    .wmask     (mem_wmask),
    .wdata_lane(mem_wdata),
    .rdata_ext (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      rdata         <= '0;
      err           <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      r_op          <= '0;
      r_lo          <= '0;
      r_wdata       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (acc_ok) begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= MemWr;
              mem_addr      <= {addr[ADDR_W-1:2], 2'b00};
              r_op          <= MemOp;
              r_lo          <= acc_lo;
              r_wdata       <= wdata;
            end else begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              err        <= 1'b1;
              rdata      <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            err        <= 1'b0;
            rdata      <= mem_we ? '0 : lane_rdata;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a size/offset arithmetic model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, MemWr;
  logic [2:0]  MemOp;
  logic [31:0] addr, wdata;
  logic        resp_valid, err;
  logic [31:0] rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  bit          rdata_known = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemWr(MemWr), .MemOp(MemOp), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned op_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit mdl_legal(input logic [2:0] op, input logic [31:0] a);
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5)) return 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    if (a % op_size(op) != 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic check_bus(input logic we, input logic [31:0] ea, input logic [31:0] emask,
                           input logic [31:0] ewd);
    chk("mem_req_valid", mem_req_valid, 1);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wmask", mem_wmask, emask);
    if (we) chk("mem_wdata", mem_wdata, ewd);
    chk("req_ready_busy", req_ready, 0);
  endtask

  // One request, issued on the first IDLE cycle; returns at the cycle resp_valid is seen.
  task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] word,
                     input int unsigned rdly, input int unsigned wdly,
                     input bit glitch, input bit rst_in_wait);
    bit          legal;
    int unsigned sz, lo, n;
    logic [31:0] m, v, emask, ewd, erd, ea;
    legal = mdl_legal(op, a);
    sz    = op_size(op);
    lo    = (a % 4) - ((a % 4) % sz);
    ea    = a & ~32'd3;
    emask = we ? (((32'd1 << sz) - 1) << lo) : 32'd0;
    ewd   = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
            (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    m     = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    v     = (word >> (8 * lo)) & m;
    if ((op == 3'd0 || op == 3'd1) && v[8*sz-1]) v = v | ~m;
    erd   = we ? 32'd0 : v;

    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("resp_valid_pulse", resp_valid, 0);
    chk("req_ready_idle", req_ready, 1);
    if (rdata_known) chk("rdata_hold", rdata, last_rdata);
    chk("err_hold", err, last_err);
    req_valid = 1'b1; MemWr = we; MemOp = op; addr = a; wdata = wd;
    @(negedge clk);
    n = 1;
    // Keep a junk request pending while busy; it must be ignored.
    MemWr = 1'($urandom); MemOp = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (!legal) begin
      chk("ill_mem_req_valid", mem_req_valid, 0);
      chk("ill_resp_valid", resp_valid, 1);
      chk("ill_err", err, 1);
      last_err = 1'b1;
      rdata_known = 1'b0;
      return;
    end
    for (int i = 0; i < int'(rdly); i++) begin
      check_bus(we, ea, emask, ewd);
      @(negedge clk);
      n++;
    end
    check_bus(we, ea, emask, ewd);
    mem_req_ready = 1'b1;
    if (glitch) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ~word;
    end
    @(negedge clk);
    n++;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    chk("wait_mem_req_valid", mem_req_valid, 0);
    chk("wait_resp_valid", resp_valid, 0);
    if (rst_in_wait) begin
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      check_reset_outputs("rst_wait");
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      #1;
      chk("rst_release_req_ready", req_ready, 1);
      last_rdata = '0; last_err = 1'b0; rdata_known = 1'b1;
      return;
    end
    for (int i = 0; i < int'(wdly); i++) begin
      @(negedge clk);
      n++;
      chk("wait_resp_valid", resp_valid, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    @(negedge clk);
    n++;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    chk("resp_valid", resp_valid, 1);
    chk("rdata", rdata, erd);
    chk("err", err, 0);
    if (rdly == 0 && wdly == 0) chk("latency", n, 3);
    last_rdata = erd; last_err = 1'b0; rdata_known = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; MemWr = 1'b0; MemOp = '0; addr = '0; wdata = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);
    txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);
    txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 0, 0);
    txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 0, 0);
    txn(1'b0, 3'b101, 32'h303, 32'h0, 32'h8765_4321, 1, 2, 0, 0);
    txn(1'b1, 3'b000, 32'h401, 32'hCAFE_F00D, 32'h0, 5, 0, 0, 0);
    txn(1'b0, 3'b001, 32'h502, 32'h0, 32'hF00D_1234, 0, 0, 1, 0);
    txn(1'b0, 3'b010, 32'h600, 32'h0, 32'h5555_AAAA, 1, 0, 0, 1);
    txn(1'b0, 3'b011, 32'h700, 32'h0, 32'h0, 0, 0, 0, 0);
    txn(1'b1, 3'b110, 32'h704, 32'h1, 32'h0, 0, 0, 0, 0);
    txn(1'b0, 3'b111, 32'h708, 32'h0, 32'h0, 0, 0, 0, 0);
    txn(1'b1, 3'b010, 32'h80C, 32'h0BAD_CAFE, 32'h0, 0, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      txn(1'($urandom), 3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 255),
          $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    req_valid = 1'b0;
    chk("final_resp_valid", resp_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
